// File: rtl/bcd_score_converter.sv
// rtl/bcd_score_converter.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module bcd_score_converter #(
  parameter int WIDTH = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam int SRW = WIDTH + 16;
  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [SRW-1:0]   sr;
  logic [SRW-1:0]   sr_adj;
  logic [3:0]       count;
  logic             pending;
  logic [WIDTH-1:0] pending_bin;

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE chains straight into a queued or simultaneous request
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == LAST) state_next = DONE;
      DONE:    state_next = (start || pending) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shift register, iteration count, pending request and registered outputs
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sr          <= '0;
      count       <= '0;
      pending     <= 1'b0;
      pending_bin <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
      thousands   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {16'b0, bin};
            count <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          sr    <= {sr_adj[SRW-2:0], 1'b0};
          count <= count + 4'd1;
          if (start) begin
            pending     <= 1'b1;
            pending_bin <= bin;
          end
        end
        DONE: begin
          ones      <= sr[WIDTH      +: 4];
          tens      <= sr[WIDTH + 4  +: 4];
          hundreds  <= sr[WIDTH + 8  +: 4];
          thousands <= sr[WIDTH + 12 +: 4];
          done      <= 1'b1;
          // A request arriving on this very edge is newer than anything pending
          if (start) begin
            sr      <= {16'b0, bin};
            count   <= '0;
            pending <= 1'b0;
          end else if (pending) begin
            sr      <= {16'b0, pending_bin};
            count   <= '0;
            pending <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_score_converter.sv
// tb/tb_bcd_score_converter.sv - self-checking bench for bcd_score_converter
module tb_bcd_score_converter;

  localparam int W = 10;

  logic         clk_100MHz = 1'b0;
  logic         reset_n;
  logic [W-1:0] bin;
  logic         start;
  logic         busy, done;
  logic [3:0]   ones, tens, hundreds, thousands;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  time prev_done_time = 0;
  time last_done_time = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_digits = '0;

  typedef struct {
    int          value;
    logic [15:0] digits;
  } vec_t;

  vec_t table_v[8];

  bcd_score_converter #(.WIDTH(W)) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .bin       (bin),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard: pop one expected digit set per done pulse; digits must hold otherwise
  always @(negedge clk_100MHz) begin
    if (!reset_n) begin
      last_digits = '0;
    end else if (done) begin
      done_count++;
      prev_done_time = last_done_time;
      last_done_time = $time;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got digits %0h with no result expected at %0t",
                 {thousands, hundreds, tens, ones}, $time);
      end else begin
        check("digits", {thousands, hundreds, tens, ones}, exp_q.pop_front());
      end
      last_digits = {thousands, hundreds, tens, ones};
    end else begin
      check("digits_hold", {thousands, hundreds, tens, ones}, last_digits);
    end
  end

  task automatic request(input int v, input bit expect_result);
    @(posedge clk_100MHz);
    #1;
    bin   = W'(v);
    start = 1'b1;
    if (expect_result) exp_q.push_back(ref_bcd(v));
    @(posedge clk_100MHz);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    check({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic latency_run(input int v, input string name);
    int busy_cycles = 0;
    int done_at = 0;
    int dones = 0;
    @(posedge clk_100MHz);
    #1;
    bin   = W'(v);
    start = 1'b1;
    exp_q.push_back(ref_bcd(v));
    @(posedge clk_100MHz);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk_100MHz);
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        if (done_at == 0) done_at = i;
      end
      if (i == 12) check({name, "_busy_low_at_done"}, 32'(busy), 32'd0);
    end
    check({name, "_done_cycle"}, 32'(done_at), 32'd12);
    check({name, "_done_width"}, 32'(dones), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd11);
  endtask

  initial begin
    int dc;
    table_v[0] = '{0,    16'h0000};
    table_v[1] = '{9,    16'h0009};
    table_v[2] = '{10,   16'h0010};
    table_v[3] = '{99,   16'h0099};
    table_v[4] = '{100,  16'h0100};
    table_v[5] = '{512,  16'h0512};
    table_v[6] = '{999,  16'h0999};
    table_v[7] = '{1023, 16'h1023};

    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (2) @(negedge clk_100MHz);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_digits", 32'({thousands, hundreds, tens, ones}), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;

    latency_run(0, "t1");
    wait_idle("t1");
    latency_run(1023, "t2");
    wait_idle("t2");

    for (int i = 0; i < 8; i++) begin
      @(posedge clk_100MHz);
      #1;
      bin   = W'(table_v[i].value);
      start = 1'b1;
      exp_q.push_back(table_v[i].digits);
      @(posedge clk_100MHz);
      #1;
      start = 1'b0;
      wait_idle("table");
    end

    request(999, 1'b1);
    request(10, 1'b1);
    wait_idle("t3");
    check("t3_spacing", 32'(last_done_time - prev_done_time), 32'd110);

    dc = done_count;
    request(100, 1'b1);
    request(5, 1'b0);
    request(7, 1'b1);
    wait_idle("t4");
    check("t4_done_count", 32'(done_count - dc), 32'd2);

    request(512, 1'b1);
    repeat (3) @(posedge clk_100MHz);
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_busy_abort", 32'(busy), 32'd0);
    check("t5_digits_abort", 32'({thousands, hundreds, tens, ones}), 32'd0);
    dc = done_count;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    repeat (15) @(negedge clk_100MHz);
    check("t5_no_done", 32'(done_count - dc), 32'd0);
    request(512, 1'b1);
    wait_idle("t5");

    for (int v = 0; v < 1024; v++) begin
      request(v, 1'b1);
      wait_idle("sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule
